// File: rtl/monument_pkg.sv
// Shared definitions for the PS/2 key decoder.
// Holds the scan-code constants, the prefix FSM state encoding, the
// direction encoding and a small one-hot helper used for keys_held updates.
package monument_pkg;

  // Scan codes (set 2)
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_e;

  // left/bottomleft, down/bottomright, up/topleft, right/topright
  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/scan_map.sv
// Combinational scan-code lookup.
// Ports:
//   code     - completed scan code (prefixes already stripped)
//   ext      - 1 when the code was preceded by E0
//   valid    - code maps to a direction key
//   dir      - direction for a valid code (dir_e encoding)
//   is_enter - code is Enter (main or keypad)
module scan_map
  import monument_pkg::*;
#(
  parameter int ALLOW_WASD = 1
) (
  input  logic [7:0] code,
  input  logic       ext,
  output logic       valid,
  output logic [1:0] dir,
  output logic       is_enter
);

  // Lookup: extended codes are the arrow keys, plain codes are WASD.
  always_comb begin
    valid    = 1'b0;
    dir      = DIR_LEFT;
    is_enter = 1'b0;
    if (ext) begin
      case (code)
        SC_UP:    begin valid = 1'b1; dir = DIR_UP;    end
        SC_DOWN:  begin valid = 1'b1; dir = DIR_DOWN;  end
        SC_LEFT:  begin valid = 1'b1; dir = DIR_LEFT;  end
        SC_RIGHT: begin valid = 1'b1; dir = DIR_RIGHT; end
        SC_ENTER: begin is_enter = 1'b1; end
        default:  begin valid = 1'b0; end
      endcase
    end else begin
      case (code)
        SC_W:     begin valid = (ALLOW_WASD != 0); dir = DIR_UP;    end
        SC_S:     begin valid = (ALLOW_WASD != 0); dir = DIR_DOWN;  end
        SC_A:     begin valid = (ALLOW_WASD != 0); dir = DIR_LEFT;  end
        SC_D:     begin valid = (ALLOW_WASD != 0); dir = DIR_RIGHT; end
        SC_ENTER: begin is_enter = 1'b1; end
        default:  begin valid = 1'b0; end
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: turns the byte stream from a PS/2 controller into
// direction move pulses, an Enter activate pulse and a held-key bitmap.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   received_data     - byte from the PS/2 controller
//   received_data_en  - one-cycle strobe qualifying received_data
//   move              - one-cycle pulse per accepted direction make
//   dir               - direction of the last accepted make
//   activate          - one-cycle pulse on Enter make
//   keys_held         - bit d set while direction d is held
module ps2_key_decoder
  import monument_pkg::*;
#(
  parameter int REPEAT_FILTER  = 1,
  parameter int ALLOW_WASD     = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       move,
  output logic [1:0] dir,
  output logic       activate,
  output logic [3:0] keys_held
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_q, move_d;
  logic             act_q, act_d;
  logic [1:0]       dir_q, dir_d;
  logic [3:0]       held_q, held_d;

  logic             is_make_s;
  logic             is_break_s;
  logic             is_ext_s;
  logic             map_valid_s;
  logic [1:0]       map_dir_s;
  logic             map_enter_s;

  scan_map #(
    .ALLOW_WASD (ALLOW_WASD)
  ) u_scan_map (
    .code     (received_data),
    .ext      (is_ext_s),
    .valid    (map_valid_s),
    .dir      (map_dir_s),
    .is_enter (map_enter_s)
  );

  // Prefix FSM next state; also flags when a byte completes a make or break.
  always_comb begin
    state_d    = state_q;
    is_make_s  = 1'b0;
    is_break_s = 1'b0;
    is_ext_s   = 1'b0;
    if (received_data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (received_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (received_data == SC_BREAK) begin
            state_d = ST_BREAK;
          end else begin
            is_make_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (received_data == SC_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else if (received_data == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            is_make_s = 1'b1;
            is_ext_s  = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_BREAK: begin
          is_break_s = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_EXT_BREAK: begin
          is_break_s = 1'b1;
          is_ext_s   = 1'b1;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if ((state_q != ST_IDLE) && (cnt_q == CNT_LAST)) begin
      // A stalled prefix is dropped silently.
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end
  end

  // Idle counter: cleared by every byte, counts only while a prefix is pending.
  always_comb begin
    cnt_d = cnt_q;
    if (received_data_en) begin
      cnt_d = '0;
    end else if ((state_q != ST_IDLE) && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Event decode: move/activate pulses, dir capture and held-key tracking.
  always_comb begin
    move_d = 1'b0;
    act_d  = 1'b0;
    dir_d  = dir_q;
    held_d = held_q;
    if (is_make_s && map_valid_s) begin
      held_d = held_q | dir_onehot(map_dir_s);
      // Typematic repeats of an already held key are not new presses.
      if ((REPEAT_FILTER != 0) && held_q[map_dir_s]) begin
        move_d = 1'b0;
      end else begin
        move_d = 1'b1;
        dir_d  = map_dir_s;
      end
    end else if (is_make_s && map_enter_s) begin
      act_d = 1'b1;
    end else if (is_break_s && map_valid_s) begin
      held_d = held_q & ~dir_onehot(map_dir_s);
    end else begin
      held_d = held_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      move_q  <= 1'b0;
      act_q   <= 1'b0;
      dir_q   <= 2'd0;
      held_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      act_q   <= act_d;
      dir_q   <= dir_d;
      held_q  <= held_d;
    end
  end

  assign move      = move_q;
  assign activate  = act_q;
  assign dir       = dir_q;
  assign keys_held = held_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder. Three instances share one byte
// stream: default parameters, REPEAT_FILTER=0 and ALLOW_WASD=0.
module tb_ps2_key_decoder;

  localparam int T = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rd;
  logic       rd_en;

  logic       move, act;
  logic [1:0] dir;
  logic [3:0] held;
  logic       move_nf, act_nf;
  logic [1:0] dir_nf;
  logic [3:0] held_nf;
  logic       move_nw, act_nw;
  logic [1:0] dir_nw;
  logic [3:0] held_nw;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ps2_key_decoder #(.REPEAT_FILTER(1), .ALLOW_WASD(1), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .received_data(rd), .received_data_en(rd_en),
    .move(move), .dir(dir), .activate(act), .keys_held(held));

  ps2_key_decoder #(.REPEAT_FILTER(0), .ALLOW_WASD(1), .TIMEOUT_CYCLES(T)) dut_nf (
    .clock(clock), .reset(reset), .received_data(rd), .received_data_en(rd_en),
    .move(move_nf), .dir(dir_nf), .activate(act_nf), .keys_held(held_nf));

  ps2_key_decoder #(.REPEAT_FILTER(1), .ALLOW_WASD(0), .TIMEOUT_CYCLES(T)) dut_nw (
    .clock(clock), .reset(reset), .received_data(rd), .received_data_en(rd_en),
    .move(move_nw), .dir(dir_nw), .activate(act_nw), .keys_held(held_nw));

  typedef struct {
    logic [7:0] data;
    logic       mv;
    logic       mv_nf;
    logic       mv_nw;
    logic [1:0] dir;
    logic       act;
    logic [3:0] held;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] d, input logic m, input logic mnf,
                              input logic mnw, input logic [1:0] dr, input logic a,
                              input logic [3:0] h);
    vec_t v;
    v.data = d; v.mv = m; v.mv_nf = mnf; v.mv_nw = mnw; v.dir = dr; v.act = a; v.held = h;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
    end
  endtask

  // Called at a falling edge; strobes one byte and returns at the next falling edge.
  task automatic send(input logic [7:0] b);
    rd    = b;
    rd_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rd_en = 1'b0;
    rd    = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    rd    = 8'h00;
    rd_en = 1'b0;

    //  data   mv nf nw dir act held
    add(8'hE0, 0, 0, 0, 0, 0, 4'b0000);
    add(8'h75, 1, 1, 1, 2, 0, 4'b0100);  // up arrow
    add(8'hE0, 0, 0, 0, 2, 0, 4'b0100);
    add(8'hF0, 0, 0, 0, 2, 0, 4'b0100);
    add(8'h75, 0, 0, 0, 2, 0, 4'b0000);  // up released
    add(8'hE0, 0, 0, 0, 2, 0, 4'b0000);
    add(8'h6B, 1, 1, 1, 0, 0, 4'b0001);  // left press
    add(8'hE0, 0, 0, 0, 0, 0, 4'b0001);
    add(8'h6B, 0, 1, 0, 0, 0, 4'b0001);  // typematic repeat
    add(8'hE0, 0, 0, 0, 0, 0, 4'b0001);
    add(8'h6B, 0, 1, 0, 0, 0, 4'b0001);  // typematic repeat
    add(8'hE0, 0, 0, 0, 0, 0, 4'b0001);
    add(8'hF0, 0, 0, 0, 0, 0, 4'b0001);
    add(8'h6B, 0, 0, 0, 0, 0, 4'b0000);  // left released, no pulse
    add(8'h1D, 1, 1, 0, 2, 0, 4'b0100);  // W
    add(8'hF0, 0, 0, 0, 2, 0, 4'b0100);
    add(8'h1D, 0, 0, 0, 2, 0, 4'b0000);
    add(8'h5A, 0, 0, 0, 2, 1, 4'b0000);  // Enter
    add(8'hE0, 0, 0, 0, 2, 0, 4'b0000);
    add(8'h5A, 0, 0, 0, 2, 1, 4'b0000);  // keypad Enter
    add(8'hE0, 0, 0, 0, 2, 0, 4'b0000);
    add(8'hF0, 0, 0, 0, 2, 0, 4'b0000);
    add(8'h5A, 0, 0, 0, 2, 0, 4'b0000);  // Enter break
    add(8'hF0, 0, 0, 0, 2, 0, 4'b0000);
    add(8'h12, 0, 0, 0, 2, 0, 4'b0000);  // unmapped break
    add(8'hE0, 0, 0, 0, 2, 0, 4'b0000);
    add(8'h74, 1, 1, 1, 3, 0, 4'b1000);  // right
    add(8'hE0, 0, 0, 0, 3, 0, 4'b1000);
    add(8'hF0, 0, 0, 0, 3, 0, 4'b1000);
    add(8'h74, 0, 0, 0, 3, 0, 4'b0000);
    add(8'hE0, 0, 0, 0, 3, 0, 4'b0000);
    add(8'hE0, 0, 0, 0, 3, 0, 4'b0000);  // repeated E0 stays extended
    add(8'h74, 1, 1, 1, 3, 0, 4'b1000);
    add(8'hE0, 0, 0, 0, 3, 0, 4'b1000);
    add(8'hF0, 0, 0, 0, 3, 0, 4'b1000);
    add(8'h74, 0, 0, 0, 3, 0, 4'b0000);
    add(8'h12, 0, 0, 0, 3, 0, 4'b0000);  // unmapped make
    add(8'hE0, 0, 0, 0, 3, 0, 4'b0000);
    add(8'h75, 1, 1, 1, 2, 0, 4'b0100);
    add(8'hE0, 0, 0, 0, 2, 0, 4'b0100);
    add(8'h72, 1, 1, 1, 1, 0, 4'b0110);  // two keys held
    add(8'hE0, 0, 0, 0, 1, 0, 4'b0110);
    add(8'hF0, 0, 0, 0, 1, 0, 4'b0110);
    add(8'h75, 0, 0, 0, 1, 0, 4'b0010);
    add(8'hE0, 0, 0, 0, 1, 0, 4'b0010);
    add(8'hF0, 0, 0, 0, 1, 0, 4'b0010);
    add(8'h72, 0, 0, 0, 1, 0, 4'b0000);

    // Reset state
    repeat (3) @(negedge clock);
    check("reset move", move, 0);
    check("reset activate", act, 0);
    check("reset dir", dir, 0);
    check("reset keys_held", held, 0);
    reset = 1'b0;
    @(negedge clock);

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].data);
      check($sformatf("v%0d move", i), move, vecs[i].mv);
      check($sformatf("v%0d move_nf", i), move_nf, vecs[i].mv_nf);
      check($sformatf("v%0d move_nw", i), move_nw, vecs[i].mv_nw);
      check($sformatf("v%0d dir", i), dir, vecs[i].dir);
      check($sformatf("v%0d activate", i), act, vecs[i].act);
      check($sformatf("v%0d keys_held", i), held, vecs[i].held);
      check($sformatf("v%0d exclusive", i), int'(move & act), 0);
    end

    // Prefix timeout: T idle cycles discard E0, so 74 is a plain (unmapped) make
    send(8'hE0);
    repeat (T) @(negedge clock);
    send(8'h74);
    check("timeout move", move, 0);
    check("timeout keys_held", held, 0);
    check("timeout dir", dir, 1);

    // One cycle short of the timeout the prefix is still pending
    send(8'hE0);
    repeat (T - 1) @(negedge clock);
    send(8'h74);
    check("pre-timeout move", move, 1);
    check("pre-timeout dir", dir, 3);
    check("pre-timeout keys_held", held, 4'b1000);
    @(negedge clock);
    check("pulse width", move, 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h74);
    check("pre-timeout release", held, 0);

    // Reset in the middle of a prefix
    send(8'hE0);
    send(8'h75);
    check("mid-reset setup dir", dir, 2);
    check("mid-reset setup held", held, 4'b0100);
    send(8'hE0);
    reset = 1'b1;
    #1;
    check("async reset keys_held", held, 0);
    check("async reset dir", dir, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send(8'h74);
    check("post-reset move", move, 0);
    check("post-reset keys_held", held, 0);
    send(8'hE0);
    send(8'h75);
    check("post-reset arrow move", move, 1);
    check("post-reset arrow dir", dir, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
